// File: rtl/tick_gen.sv
// tick_gen: single-cycle enable pulses for the display counter.
// A down-counting divider produces periodic ticks at a switch-selected rate,
// and a synchronized, debounced pushbutton produces one tick per press.
module tick_gen #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rate_sel,
  input  logic       run,
  input  logic       step_n,
  output logic       tick,
  output logic       step_held
);

  localparam logic [CNT_W-1:0] P1_M1 = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] P2_M1 = CNT_W'(2 * CLK_HZ - 1);
  localparam logic [CNT_W-1:0] P4_M1 = CNT_W'(4 * CLK_HZ - 1);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Divider state
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       rate_q;
  logic             reload_pend, reload_nxt;
  logic             timer_tick;

  // Button path state
  logic            sync_s1, sync_s2;
  logic            db_lvl, db_lvl_nxt;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;
  logic            step_tick;

  // Reload value (period minus one) for a given rate code
  function automatic logic [CNT_W-1:0] reload_val(input logic [1:0] r);
    case (r)
      2'b00:   reload_val = '0;
      2'b01:   reload_val = P1_M1;
      2'b10:   reload_val = P2_M1;
      default: reload_val = P4_M1;
    endcase
  endfunction

  // Divider next state: a pending reload or rate change restarts the period,
  // a stopped divider sits at its reload value, otherwise count down to a tick
  always_comb begin
    cnt_nxt    = cnt;
    reload_nxt = reload_pend;
    timer_tick = 1'b0;
    if (reload_pend || (rate_sel != rate_q)) begin
      cnt_nxt    = reload_val(rate_sel);
      reload_nxt = 1'b0;
    end else if (!run) begin
      cnt_nxt = reload_val(rate_q);
    end else if (cnt == '0) begin
      timer_tick = 1'b1;
      cnt_nxt    = reload_val(rate_q);
    end else begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // Debounce next state: accept a new level after it has differed for the full
  // window; only a newly accepted press (level 0) yields a step tick
  always_comb begin
    db_lvl_nxt = db_lvl;
    db_cnt_nxt = '0;
    step_tick  = 1'b0;
    if (sync_s2 != db_lvl) begin
      if (db_cnt == DB_LAST) begin
        db_lvl_nxt = sync_s2;
        step_tick  = ~sync_s2;
      end else begin
        db_cnt_nxt = db_cnt + DB_W'(1);
      end
    end
  end

  // Divider registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      rate_q      <= 2'b00;
      reload_pend <= 1'b1;
    end else begin
      cnt         <= cnt_nxt;
      rate_q      <= rate_sel;
      reload_pend <= reload_nxt;
    end
  end

  // Button synchronizer and debounce registers (idle level is released = 1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_s1 <= 1'b1;
      sync_s2 <= 1'b1;
      db_lvl  <= 1'b1;
      db_cnt  <= '0;
    end else begin
      sync_s1 <= step_n;
      sync_s2 <= sync_s1;
      db_lvl  <= db_lvl_nxt;
      db_cnt  <= db_cnt_nxt;
    end
  end

  // Registered outputs; coincident timer and step ticks merge into one pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick      <= 1'b0;
      step_held <= 1'b0;
    end else begin
      tick      <= timer_tick | step_tick;
      step_held <= ~db_lvl_nxt;
    end
  end

endmodule
